// File: rtl/keypad_entry_unit_pkg.sv
// Shared key codes, FSM state types and keypad lookup helpers for keypad_entry_unit.
package keypad_entry_unit_pkg;

  localparam logic [3:0] KEY_0     = 4'd0;
  localparam logic [3:0] KEY_1     = 4'd1;
  localparam logic [3:0] KEY_2     = 4'd2;
  localparam logic [3:0] KEY_3     = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_7     = 4'd7;
  localparam logic [3:0] KEY_8     = 4'd8;
  localparam logic [3:0] KEY_9     = 4'd9;
  localparam logic [3:0] KEY_SIGN  = 4'd10;
  localparam logic [3:0] KEY_BKSP  = 4'd11;
  localparam logic [3:0] KEY_CLR   = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd13;
  localparam logic [3:0] KEY_NONE  = 4'd15;

  typedef enum logic [1:0] {
    SC_SCAN,
    SC_DEBOUNCE,
    SC_WAIT_RELEASE
  } scan_state_t;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_CONVERT,
    ST_DONE
  } entry_state_t;

  // Index of the lowest asserted bit of an active-high one-hot row vector.
  function automatic logic [1:0] row_index(input logic [3:0] row_n);
    if (row_n[0])      return 2'd0;
    else if (row_n[1]) return 2'd1;
    else if (row_n[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  // '*' and '#' map to KEY_NONE so the entry FSM ignores them.
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:    return KEY_1;
      4'd1:    return KEY_2;
      4'd2:    return KEY_3;
      4'd3:    return KEY_SIGN;
      4'd4:    return KEY_4;
      4'd5:    return KEY_5;
      4'd6:    return KEY_6;
      4'd7:    return KEY_BKSP;
      4'd8:    return KEY_7;
      4'd9:    return KEY_8;
      4'd10:   return KEY_9;
      4'd11:   return KEY_CLR;
      4'd13:   return KEY_0;
      4'd15:   return KEY_ENTER;
      default: return KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/keypad_entry_unit_scanner.sv
// keypad_scanner: column scan, press/release debounce, one-cycle key strobe.
module keypad_scanner
  import keypad_entry_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_strobe,
  output logic [3:0] key_code
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  scan_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] scan_cnt, scan_cnt_n;
  logic [1:0]    col_idx, col_idx_n;
  logic [3:0]    row_lat, row_lat_n;
  logic          strobe_n;
  logic [3:0]    code_n;
  logic [3:0]    row_n;
  logic          one_low;

  assign row_n   = ~row;
  assign one_low = (row_n != 4'h0) && ((row_n & (row_n - 4'd1)) == 4'h0);
  assign col     = ~(4'b0001 << col_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SC_SCAN;
      cnt        <= '0;
      scan_cnt   <= '0;
      col_idx    <= '0;
      row_lat    <= '1;
      key_strobe <= 1'b0;
      key_code   <= KEY_NONE;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      scan_cnt   <= scan_cnt_n;
      col_idx    <= col_idx_n;
      row_lat    <= row_lat_n;
      key_strobe <= strobe_n;
      key_code   <= code_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    scan_cnt_n = scan_cnt;
    col_idx_n  = col_idx;
    row_lat_n  = row_lat;
    strobe_n   = 1'b0;
    code_n     = key_code;
    unique case (state)
      SC_SCAN: begin
        // Column stays put on the detection cycle so debounce sees the same key.
        if (one_low) begin
          state_n    = SC_DEBOUNCE;
          row_lat_n  = row;
          cnt_n      = '0;
          scan_cnt_n = '0;
        end else if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
          scan_cnt_n = '0;
          col_idx_n  = col_idx + 2'd1;
        end else begin
          scan_cnt_n = scan_cnt + SW'(1);
        end
      end
      SC_DEBOUNCE: begin
        if (row != row_lat) begin
          state_n = SC_SCAN;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_n  = SC_WAIT_RELEASE;
          cnt_n    = '0;
          strobe_n = 1'b1;
          code_n   = key_lookup(row_index(~row_lat), col_idx);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SC_WAIT_RELEASE: begin
        if (row != 4'hF) begin
          cnt_n = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_n = SC_SCAN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = SC_SCAN;
    endcase
  end

endmodule

// File: rtl/keypad_entry_unit.sv
// Keypad digit entry with sequential BCD-to-two's-complement conversion and saturation.
// Optional KEYPAD_ECHO_EN adds bcd_echo/sign_echo display outputs.
module keypad_entry_unit
  import keypad_entry_unit_pkg::*;
#(
  parameter int DIGITS          = 3,
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  output logic             overflow,
  output logic             busy,
  output logic [2:0]       digit_count
`ifdef KEYPAD_ECHO_EN
  ,
  output logic [4*DIGITS-1:0] bcd_echo,
  output logic                sign_echo
`endif
);

  localparam int AW = WIDTH + 4;
  localparam int XW = AW + 4;
  localparam logic [AW-1:0] NEG_LIMIT = AW'(1) << (WIDTH - 1);
  localparam logic [AW-1:0] POS_LIMIT = NEG_LIMIT - AW'(1);

  logic       key_strobe;
  logic [3:0] key_code;

  keypad_scanner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SCAN_CYCLES    (SCAN_CYCLES)
  ) u_scanner (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_strobe(key_strobe),
    .key_code  (key_code)
  );

  entry_state_t               state, state_n;
  logic [DIGITS-1:0][3:0]     bcd, bcd_n;
  logic [2:0]                 count, count_n;
  logic [2:0]                 idx, idx_n;
  logic                       neg, neg_n;
  logic [AW-1:0]              acc, acc_n;
  logic                       carry, carry_n;
  logic [WIDTH-1:0]           value_q, value_n;
  logic                       ovf_q, ovf_n;

  logic [3:0]       cur_digit;
  logic [XW-1:0]    product;
  logic [AW-1:0]    acc_step, conv_acc, limit;
  logic             carry_step, conv_carry, res_ovf;
  logic [WIDTH-1:0] mag, res_value;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_ENTRY;
      bcd     <= '0;
      count   <= '0;
      idx     <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      carry   <= 1'b0;
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      bcd     <= bcd_n;
      count   <= count_n;
      idx     <= idx_n;
      neg     <= neg_n;
      acc     <= acc_n;
      carry   <= carry_n;
      value_q <= value_n;
      ovf_q   <= ovf_n;
    end
  end

  // One MSD-first accumulation step; idx counts remaining digits, so idx-1 is the next one.
  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i + 1)) cur_digit = bcd[i];
    end
    product    = XW'(acc) * XW'(10) + XW'(cur_digit);
    acc_step   = product[AW-1:0];
    carry_step = carry | (|product[XW-1:AW]);
    conv_acc   = (state == ST_CONVERT) ? acc_step : '0;
    conv_carry = (state == ST_CONVERT) ? carry_step : 1'b0;
    limit      = neg ? NEG_LIMIT : POS_LIMIT;
    res_ovf    = conv_carry || (conv_acc > limit);
    mag        = res_ovf ? limit[WIDTH-1:0] : conv_acc[WIDTH-1:0];
    res_value  = neg ? (~mag + WIDTH'(1)) : mag;
  end

  always_comb begin
    state_n = state;
    bcd_n   = bcd;
    count_n = count;
    idx_n   = idx;
    neg_n   = neg;
    acc_n   = acc;
    carry_n = carry;
    value_n = value_q;
    ovf_n   = ovf_q;
    unique case (state)
      ST_ENTRY: begin
        if (key_strobe) begin
          if (key_code <= KEY_9) begin
            if (count < 3'(DIGITS)) begin
              for (int unsigned i = 1; i < DIGITS; i++) bcd_n[i] = bcd[i-1];
              bcd_n[0] = key_code;
              count_n  = count + 3'd1;
            end
          end else if (key_code == KEY_SIGN) begin
            neg_n = ~neg;
          end else if (key_code == KEY_BKSP) begin
            if (count != 3'd0) begin
              for (int unsigned i = 0; i + 1 < DIGITS; i++) bcd_n[i] = bcd[i+1];
              bcd_n[DIGITS-1] = '0;
              count_n = count - 3'd1;
            end
          end else if (key_code == KEY_CLR) begin
            bcd_n   = '0;
            count_n = '0;
            neg_n   = 1'b0;
          end else if (key_code == KEY_ENTER) begin
            acc_n   = '0;
            carry_n = 1'b0;
            idx_n   = count;
            if (count == 3'd0) begin
              state_n = ST_DONE;
              value_n = res_value;
              ovf_n   = res_ovf;
            end else begin
              state_n = ST_CONVERT;
            end
          end
        end
      end
      ST_CONVERT: begin
        acc_n   = acc_step;
        carry_n = carry_step;
        idx_n   = idx - 3'd1;
        if (idx == 3'd1) begin
          state_n = ST_DONE;
          value_n = res_value;
          ovf_n   = res_ovf;
        end
      end
      ST_DONE: begin
        bcd_n   = '0;
        count_n = '0;
        neg_n   = 1'b0;
        state_n = ST_ENTRY;
      end
      default: state_n = ST_ENTRY;
    endcase
  end

  assign value       = value_q;
  assign overflow    = ovf_q;
  assign value_valid = (state == ST_DONE);
  assign busy        = (state != ST_ENTRY);
  assign digit_count = count;

`ifdef KEYPAD_ECHO_EN
  assign bcd_echo  = bcd;
  assign sign_echo = neg;
`endif

endmodule
